// File: rtl/tick_timekeeper_if.sv
// tick_timekeeper_if: tick input, time load bus and time/status outputs of tick_timekeeper (alarm signals under ALARM_MATCH_EN)
interface tick_timekeeper_if;
  logic       tick_in;
  logic       load;
  logic [4:0] load_hh;
  logic [5:0] load_mm;
  logic [5:0] load_ss;
  logic       sec_pulse;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       stall;
`ifdef ALARM_MATCH_EN
  logic       alarm_on;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       alarm_hit;
  modport master (
    output tick_in, load, load_hh, load_mm, load_ss, alarm_on, alarm_hh, alarm_mm,
    input  sec_pulse, hh, mm, ss, stall, alarm_hit
  );
  modport slave (
    input  tick_in, load, load_hh, load_mm, load_ss, alarm_on, alarm_hh, alarm_mm,
    output sec_pulse, hh, mm, ss, stall, alarm_hit
  );
`else
  modport master (
    output tick_in, load, load_hh, load_mm, load_ss,
    input  sec_pulse, hh, mm, ss, stall
  );
  modport slave (
    input  tick_in, load, load_hh, load_mm, load_ss,
    output sec_pulse, hh, mm, ss, stall
  );
`endif
endinterface

// File: rtl/tick_timekeeper.sv
// tick_timekeeper: syncs tick_in, prescales its edges to a 1 s strobe, keeps 24 h hh:mm:ss, flags a stalled divider; ALARM_MATCH_EN adds an alarm compare
module tick_timekeeper #(
  parameter int TICKS_PER_SEC = 1,
  parameter int STALL_CYCLES  = 65535
) (
  input logic              clkin,
  input logic              reset,
  tick_timekeeper_if.slave bus
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [15:0] S_LAST = 16'(STALL_CYCLES - 1);
  localparam logic [15:0] S_MAX  = 16'(STALL_CYCLES);
  logic          sync0, sync1, prev, tick_edge;
  logic [PW-1:0] presc;
  logic [15:0]   stall_cnt;
  logic          sec_pulse, stall, sec_wrap, count_sec, ss_carry, mm_carry;
  logic [4:0]    hh, hh_inc, hh_ld;
  logic [5:0]    mm, mm_inc, mm_ld;
  logic [5:0]    ss, ss_inc, ss_ld;
  assign tick_edge     = sync1 & ~prev;
  assign sec_wrap      = presc == P_LAST;
  assign count_sec     = tick_edge & sec_wrap & ~bus.load;
  assign bus.sec_pulse = sec_pulse;
  assign bus.hh        = hh;
  assign bus.mm        = mm;
  assign bus.ss        = ss;
  assign bus.stall     = stall;
  // time one second ahead (ripple carry ss -> mm -> hh) and range-clamped load fields
  always_comb begin
    ss_carry = ss == 6'd59;
    mm_carry = ss_carry & (mm == 6'd59);
    ss_inc   = ss_carry ? 6'd0 : ss + 6'd1;
    mm_inc   = ss_carry ? ((mm == 6'd59) ? 6'd0 : mm + 6'd1) : mm;
    hh_inc   = mm_carry ? ((hh == 5'd23) ? 5'd0 : hh + 5'd1) : hh;
    hh_ld    = (bus.load_hh > 5'd23) ? 5'd0 : bus.load_hh;
    mm_ld    = (bus.load_mm > 6'd59) ? 6'd0 : bus.load_mm;
    ss_ld    = (bus.load_ss > 6'd59) ? 6'd0 : bus.load_ss;
  end
  // two-flop synchroniser for the asynchronous tick plus one history flop for edge detect
  always_ff @(posedge clkin) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= bus.tick_in;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end
  // prescaler and time of day; a load wins over a coincident edge, which is dropped
  always_ff @(posedge clkin) begin
    if (!reset) begin
      presc     <= '0;
      sec_pulse <= 1'b0;
      hh        <= 5'd0;
      mm        <= 6'd0;
      ss        <= 6'd0;
    end else if (bus.load) begin
      presc     <= '0;
      sec_pulse <= 1'b0;
      hh        <= hh_ld;
      mm        <= mm_ld;
      ss        <= ss_ld;
    end else if (tick_edge) begin
      presc     <= sec_wrap ? '0 : presc + PW'(1);
      sec_pulse <= sec_wrap;
      if (sec_wrap) begin
        hh <= hh_inc;
        mm <= mm_inc;
        ss <= ss_inc;
      end
    end else begin
      sec_pulse <= 1'b0;
    end
  end
  // edge-free cycle counter; stall is sticky until the next edge and ignores load
  always_ff @(posedge clkin) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
      stall     <= 1'b0;
    end else if (tick_edge) begin
      stall_cnt <= 16'd0;
      stall     <= 1'b0;
    end else begin
      if (stall_cnt != S_MAX) stall_cnt <= stall_cnt + 16'd1;
      if (stall_cnt == S_LAST) stall <= 1'b1;
    end
  end
`ifdef ALARM_MATCH_EN
  logic alarm_hit;
  assign bus.alarm_hit = alarm_hit;
  // fires only on a counted second whose new time is alarm_hh:alarm_mm:00, never on a load
  always_ff @(posedge clkin) begin
    if (!reset) alarm_hit <= 1'b0;
    else alarm_hit <= count_sec & bus.alarm_on & (hh_inc == bus.alarm_hh) & (mm_inc == bus.alarm_mm) & (ss_inc == 6'd0);
  end
`endif
endmodule

// File: tb/tb_tick_timekeeper.sv
// tb_tick_timekeeper: drives two tick_timekeeper instances (1 and 4 ticks/s) and checks them against a seconds-of-day model
module tb_tick_timekeeper;
  logic clkin = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, ld = 1'b0, al_on = 1'b0;
  logic [4:0] lhh = '0, ahh = '0;
  logic [5:0] lmm = '0, lss = '0, amm = '0;
  int n_cmp = 0, n_err = 0;
  always #5 clkin = ~clkin;
  tick_timekeeper_if b1();
  tick_timekeeper_if b2();
  assign b1.tick_in = tick;
  assign b1.load = ld;
  assign b1.load_hh = lhh;
  assign b1.load_mm = lmm;
  assign b1.load_ss = lss;
  assign b2.tick_in = tick;
  assign b2.load = ld;
  assign b2.load_hh = lhh;
  assign b2.load_mm = lmm;
  assign b2.load_ss = lss;
`ifdef ALARM_MATCH_EN
  assign b1.alarm_on = al_on;
  assign b1.alarm_hh = ahh;
  assign b1.alarm_mm = amm;
  assign b2.alarm_on = al_on;
  assign b2.alarm_hh = ahh;
  assign b2.alarm_mm = amm;
`endif
  tick_timekeeper #(.TICKS_PER_SEC(1), .STALL_CYCLES(16)) dut1 (.clkin(clkin), .reset(reset), .bus(b1));
  tick_timekeeper #(.TICKS_PER_SEC(4), .STALL_CYCLES(40)) dut2 (.clkin(clkin), .reset(reset), .bus(b2));
  logic       d_sp[2], d_st[2], d_ah[2];
  logic [4:0] d_hh[2];
  logic [5:0] d_mm[2], d_ss[2];
  assign d_sp[0] = b1.sec_pulse;
  assign d_sp[1] = b2.sec_pulse;
  assign d_st[0] = b1.stall;
  assign d_st[1] = b2.stall;
  assign d_hh[0] = b1.hh;
  assign d_hh[1] = b2.hh;
  assign d_mm[0] = b1.mm;
  assign d_mm[1] = b2.mm;
  assign d_ss[0] = b1.ss;
  assign d_ss[1] = b2.ss;
`ifdef ALARM_MATCH_EN
  assign d_ah[0] = b1.alarm_hit;
  assign d_ah[1] = b2.alarm_hit;
`else
  assign d_ah[0] = 1'b0;
  assign d_ah[1] = 1'b0;
`endif
  int tps[2] = '{1, 4};
  int scy[2] = '{16, 40};
  bit h0[2], h1[2], h2[2], msp[2], mhit[2];
  int pc[2], secs[2], idle[2];
  bit started = 0, e;
  function automatic int fld(int v, int lim);
    return (v >= lim) ? 0 : v;
  endfunction
  task automatic chk(string name, int inst, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, inst + 1, $time, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clkin);
  endtask
  // model: time as seconds since midnight, tick history as a 3-deep sample list, stall as edge-free cycle count
  always @(posedge clkin) begin
    started = 1;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        h0[i] = 0; h1[i] = 0; h2[i] = 0;
        pc[i] = 0; secs[i] = 0; idle[i] = 0; msp[i] = 0; mhit[i] = 0;
      end else begin
        e = h1[i] & ~h2[i];
        h2[i] = h1[i]; h1[i] = h0[i]; h0[i] = tick;
        msp[i] = 0; mhit[i] = 0;
        if (ld) begin
          secs[i] = fld(lhh, 24) * 3600 + fld(lmm, 60) * 60 + fld(lss, 60);
          pc[i] = 0;
        end else if (e) begin
          pc[i]++;
          if (pc[i] == tps[i]) begin
            pc[i] = 0;
            msp[i] = 1;
            secs[i] = (secs[i] + 1) % 86400;
            mhit[i] = al_on && secs[i] / 3600 == ahh && (secs[i] / 60) % 60 == amm && secs[i] % 60 == 0;
          end
        end
        idle[i] = e ? 0 : idle[i] + 1;
      end
    end
  end
  // every-cycle comparison of both instances against the model
  always @(negedge clkin) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("sec_pulse", i, d_sp[i], msp[i]);
        chk("hh", i, d_hh[i], secs[i] / 3600);
        chk("mm", i, d_mm[i], (secs[i] / 60) % 60);
        chk("ss", i, d_ss[i], secs[i] % 60);
        chk("stall", i, d_st[i], int'(idle[i] >= scy[i]));
`ifdef ALARM_MATCH_EN
        chk("alarm_hit", i, d_ah[i], mhit[i]);
`endif
      end
    end
  end
  task automatic load_time(int h, int m, int s);
    lhh = 5'(h); lmm = 6'(m); lss = 6'(s); ld = 1'b1;
    cyc(1);
    ld = 1'b0;
  endtask
  task automatic pulse();
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    cyc(3);
  endtask
  initial begin
    cyc(3);
    chk("rst_sec_pulse", 0, b1.sec_pulse, 0);
    chk("rst_hh", 0, b1.hh, 0);
    chk("rst_mm", 0, b1.mm, 0);
    chk("rst_ss", 0, b1.ss, 0);
    chk("rst_stall", 0, b1.stall, 0);
    reset = 1'b1;
    cyc(2);
    tick = 1'b1;
    cyc(2);
    chk("t1_early_pulse", 0, b1.sec_pulse, 0);
    cyc(1);
    chk("t1_pulse", 0, b1.sec_pulse, 1);
    chk("t1_ss", 0, b1.ss, 1);
    cyc(1);
    chk("t1_pulse_end", 0, b1.sec_pulse, 0);
    tick = 1'b0;
    cyc(3);
    load_time(23, 59, 58);
    pulse();
    chk("t2_hh", 0, b1.hh, 23);
    chk("t2_mm", 0, b1.mm, 59);
    chk("t2_ss", 0, b1.ss, 59);
    pulse();
    chk("t2_wrap_hh", 0, b1.hh, 0);
    chk("t2_wrap_mm", 0, b1.mm, 0);
    chk("t2_wrap_ss", 0, b1.ss, 0);
    load_time(0, 0, 0);
    repeat (8) pulse();
    chk("t3_ss_tps4", 1, b2.ss, 2);
    chk("t3_ss_tps1", 0, b1.ss, 8);
    load_time(24, 60, 61);
    chk("t3_clamp_hh", 1, b2.hh, 0);
    chk("t3_clamp_mm", 1, b2.mm, 0);
    chk("t3_clamp_ss", 1, b2.ss, 0);
    tick = 1'b1;
    cyc(2);
    load_time(10, 20, 30);
    chk("t4_no_pulse", 0, b1.sec_pulse, 0);
    chk("t4_ss", 0, b1.ss, 30);
    chk("t4_mm", 1, b2.mm, 20);
    cyc(1);
    chk("t4_held", 0, b1.ss, 30);
    tick = 1'b0;
    cyc(3);
    repeat (3) pulse();
    chk("t4_presc_3", 1, b2.ss, 30);
    chk("t4_tps1_3", 0, b1.ss, 33);
    pulse();
    chk("t4_presc_4", 1, b2.ss, 31);
    cyc(20);
    chk("t5_stall16", 0, b1.stall, 1);
    chk("t5_stall40_not_yet", 1, b2.stall, 0);
    tick = 1'b1;
    cyc(2);
    chk("t5_stall_before_edge", 0, b1.stall, 1);
    cyc(1);
    chk("t5_stall_cleared", 0, b1.stall, 0);
    tick = 1'b0;
    cyc(45);
    chk("t5_stall40", 1, b2.stall, 1);
    chk("t5_time_frozen", 0, b1.ss, 35);
    tick = 1'b1;
    lhh = 5'd5; ld = 1'b1;
    reset = 1'b0;
    cyc(2);
    ld = 1'b0;
    chk("rst_mid_hh", 0, b1.hh, 0);
    chk("rst_mid_stall", 1, b2.stall, 0);
    reset = 1'b1;
    cyc(2);
    chk("rel_ss_early", 0, b1.ss, 0);
    cyc(1);
    chk("rel_edge_counted", 0, b1.ss, 1);
    tick = 1'b0;
    cyc(3);
`ifdef ALARM_MATCH_EN
    ahh = 5'd7; amm = 6'd30; al_on = 1'b1;
    load_time(7, 29, 59);
    tick = 1'b1;
    cyc(3);
    chk("t6_hit", 0, b1.alarm_hit, 1);
    chk("t6_mm", 0, b1.mm, 30);
    cyc(1);
    chk("t6_hit_end", 0, b1.alarm_hit, 0);
    tick = 1'b0;
    cyc(3);
    al_on = 1'b0;
    load_time(7, 29, 59);
    tick = 1'b1;
    cyc(3);
    chk("t6_off", 0, b1.alarm_hit, 0);
    tick = 1'b0;
    cyc(3);
    al_on = 1'b1;
    load_time(7, 30, 0);
    cyc(2);
    chk("t6_load_no_hit", 0, b1.alarm_hit, 0);
`endif
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
